bus_transaction_controller: RTL and testbench
=============================================

BUS_TRANSACTION_CONTROLLER -- requirements
Module: bus_transaction_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waited on one handshake_2 edge before abort.
REQ-002 SHALL have parameter ADDR_W, default 8, width of register address.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  host requests a transaction.
REQ-006 cmd_ready  out  1  controller idle and can accept; accept when cmd_valid & cmd_ready.
REQ-007 cmd_RW  in  1  1 = read register, 0 = write register.
REQ-008 cmd_reg_address  in  ADDR_W  target register number.
REQ-009 cmd_data  in  32  write data; ignored for reads.
REQ-010 resp_valid  out  1  one-cycle pulse, response fields valid.
REQ-011 resp_data  out  32  word captured in phase 1 (reads); 0 for writes.
REQ-012 resp_status  out  32  word captured in phase 2.
REQ-013 resp_fault  out  1  nFault seen low during transaction.
REQ-014 resp_timeout  out  1  transaction aborted by watchdog.
REQ-015 reg_address  out  ADDR_W  bus register address, held for whole transaction.
REQ-016 RW  out  1  bus direction, copy of latched cmd_RW.
REQ-017 register_address_valid  out  1  high from ADDR state until transaction ends.
REQ-018 handshake_1  out  1  controller strobe.
REQ-019 handshake_2  in  1  subsystem acknowledge.
REQ-020 data_out  out  32  write word to subsystem, driven only in phase 1 of a write, else 0.
REQ-021 data_in  in  32  word from subsystem.
REQ-022 nFault  in  1  active-low fault; tri-state 'z treated as not-fault (only literal 0 is fault).

Function
REQ-023 States SHALL be IDLE, ADDR, P_ACK, P_REL, DONE, ABORT; phase counter ph in {1,2}.
REQ-024 IDLE: cmd_ready=1; on accept latch address/RW/data, ph=1, clear fault flag, go ADDR.
REQ-025 ADDR: one cycle, register_address_valid=1, handshake_1=0, go P_ACK.
REQ-026 P_ACK: handshake_1=1; on handshake_2=1 capture data_in (ph1 read -> resp_data, ph2 -> resp_status), go P_REL.
REQ-027 P_REL: handshake_1=0; on handshake_2=0: ph=1 -> ph=2, go P_ACK; ph=2 -> go DONE.
REQ-028 DONE: resp_valid=1 one cycle, register_address_valid=0, go IDLE; latency write/read with immediate acks = 6 cycles accept->resp_valid.
REQ-029 Fault flag SHALL set on any cycle outside IDLE with nFault==0 and report in resp_fault.
REQ-030 Watchdog counter SHALL clear on entering P_ACK/P_REL and increment each cycle there; reaching TIMEOUT_CYCLES -> ABORT.
REQ-031 ABORT: handshake_1=0, register_address_valid=0; wait handshake_2=0, then resp_valid=1 with resp_timeout=1, resp_status=32'hFFFFFFFF, go IDLE.
REQ-032 cmd_valid outside IDLE SHALL be ignored (cmd_ready=0); no queuing.
REQ-033 handshake_2 already high on entering P_ACK counts as ack the same cycle.
REQ-034 Response fields SHALL hold until next accept; resp_valid is only a pulse.

Reset
REQ-035 reset SHALL force IDLE mid-transaction in one cycle; all outputs 0 except cmd_ready=1; captured words, flags, counters cleared.
REQ-036 Reset SHALL take priority over every transition in the same cycle.

Configuration
REQ-037 Macro BUS_TIMEOUT_EN defined: watchdog and ABORT per REQ-030/031 compiled in.
REQ-038 BUS_TIMEOUT_EN undefined: no counter, no ABORT state; waits indefinitely; resp_timeout tied 0.

Verification
REQ-039 Write addr 8'h05 data 32'h12345678, model acks in 1 cycle -> data_out=32'h12345678 in ph1, resp_valid 6 cycles after accept, resp_fault=0.
REQ-040 Read addr 8'h03, model returns 32'hCAFEF00D then 32'h00000001 -> resp_data=32'hCAFEF00D, resp_status=32'h00000001.
REQ-041 Read unmapped addr, error model returns 32'h55555555/32'hAAAAAAAA with nFault=0 -> resp_fault=1, resp_data=32'h55555555.
REQ-042 No handshake_2 response, TIMEOUT_CYCLES=16, BUS_TIMEOUT_EN defined -> resp_timeout=1, resp_status=32'hFFFFFFFF within 16+2 cycles.
REQ-043 reset asserted in P_REL ph2 -> next cycle state IDLE, handshake_1=0, cmd_ready=1, no resp_valid.
REQ-044 cmd_valid held high during busy transaction -> exactly one transaction per accept, second accepted only after DONE.

Source files
------------

// File: rtl/bus_transaction_controller.sv
// Two-phase handshake register bus master: ADDR, then ack/release of handshake_2 for phase 1 (data) and phase 2 (status).
// Define BUS_TIMEOUT_EN to compile in the per-edge watchdog and ABORT path.
module bus_transaction_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_RW,
  input  logic [ADDR_W-1:0] cmd_reg_address,
  input  logic [31:0]       cmd_data,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [31:0]       resp_status,
  output logic              resp_fault,
  output logic              resp_timeout,
  output logic [ADDR_W-1:0] reg_address,
  output logic              RW,
  output logic              register_address_valid,
  output logic              handshake_1,
  input  logic              handshake_2,
  output logic [31:0]       data_out,
  input  logic [31:0]       data_in,
  input  logic              nFault
);

  typedef enum logic [2:0] {
    IDLE, ADDR, P_ACK, P_REL, DONE
`ifdef BUS_TIMEOUT_EN
    , ABORT
`endif
  } state_e;

  state_e            state_q, state_d;
  logic              ph2_q, ph2_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       status_q, status_d;
  logic              fault_q, fault_d;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             tmo_q, tmo_d;
  logic             wd_expired;
  assign wd_expired = (wd_q == WD_LAST);
`endif

  always_comb begin
    state_d   = state_q;
    ph2_d     = ph2_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    fault_d   = fault_q;
    cmd_ready              = 1'b0;
    resp_valid             = 1'b0;
    handshake_1            = 1'b0;
    register_address_valid = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo_d = tmo_q;
`endif

    // Only a literal 0 is a fault; an undriven line compares unknown and is ignored.
    if (state_q != IDLE && nFault == 1'b0) fault_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d   = cmd_reg_address;
          rw_d     = cmd_RW;
          wdata_d  = cmd_RW ? '0 : cmd_data;
          rdata_d  = '0;
          status_d = '0;
          fault_d  = 1'b0;
          ph2_d    = 1'b0;
`ifdef BUS_TIMEOUT_EN
          tmo_d    = 1'b0;
`endif
          state_d  = ADDR;
        end
      end
      ADDR: begin
        register_address_valid = 1'b1;
        state_d = P_ACK;
      end
      P_ACK: begin
        register_address_valid = 1'b1;
        handshake_1            = 1'b1;
        if (handshake_2) begin
          if (ph2_q)     status_d = data_in;
          else if (rw_q) rdata_d  = data_in;
          state_d = P_REL;
        end
`ifdef BUS_TIMEOUT_EN
        else if (wd_expired) begin
          tmo_d    = 1'b1;
          status_d = '1;
          state_d  = ABORT;
        end
`endif
      end
      P_REL: begin
        register_address_valid = 1'b1;
        if (!handshake_2) begin
          if (ph2_q) state_d = DONE;
          else begin
            ph2_d   = 1'b1;
            state_d = P_ACK;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (wd_expired) begin
          tmo_d    = 1'b1;
          status_d = '1;
          state_d  = ABORT;
        end
`endif
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
`ifdef BUS_TIMEOUT_EN
      ABORT: begin
        if (!handshake_2) begin
          resp_valid = 1'b1;
          state_d    = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  // Restart on every state change so each handshake edge gets its own budget.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q)                      wd_d = '0;
    else if (state_q == P_ACK || state_q == P_REL) wd_d = wd_q + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ph2_q    <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      fault_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wd_q     <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ph2_q    <= ph2_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      fault_q  <= fault_d;
`ifdef BUS_TIMEOUT_EN
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    data_out = '0;
    if (!rw_q && !ph2_q && (state_q == ADDR || state_q == P_ACK || state_q == P_REL))
      data_out = wdata_q;
  end

  assign reg_address = addr_q;
  assign RW          = rw_q;
  assign resp_data   = rdata_q;
  assign resp_status = status_q;
  assign resp_fault  = fault_q;
`ifdef BUS_TIMEOUT_EN
  assign resp_timeout = tmo_q;
`else
  assign resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_transaction_controller.sv
// Directed bench for bus_transaction_controller: a subsystem model answers handshakes and a scoreboard checks responses.
module tb_bus_transaction_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_RW;
  logic [7:0]  cmd_reg_address;
  logic [31:0] cmd_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] resp_status;
  logic        resp_fault;
  logic        resp_timeout;
  logic [7:0]  reg_address;
  logic        RW;
  logic        register_address_valid;
  logic        handshake_1;
  logic        handshake_2;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        nFault;

  bus_transaction_controller #(.TIMEOUT_CYCLES(16), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_RW(cmd_RW),
    .cmd_reg_address(cmd_reg_address), .cmd_data(cmd_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_status(resp_status),
    .resp_fault(resp_fault), .resp_timeout(resp_timeout),
    .reg_address(reg_address), .RW(RW), .register_address_valid(register_address_valid),
    .handshake_1(handshake_1), .handshake_2(handshake_2),
    .data_out(data_out), .data_in(data_in), .nFault(nFault)
  );

  always #5 clk = ~clk;

  // Subsystem model. mode 0: ack follows strobe combinationally; 1: never acks; 2: ack stuck high.
  logic [1:0]  mode;
  logic [31:0] d1, d2;
  int unsigned acks = 0;
  int unsigned ack_base;
  assign handshake_2 = (mode == 2'd0) ? handshake_1 : (mode == 2'd2);
  assign data_in     = (acks == ack_base) ? d1 : d2;
  always @(posedge clk) if (handshake_1 && handshake_2) acks <= acks + 1;

  int unsigned cyc = 0;
  int unsigned accepts = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready && !reset) accepts <= accepts + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [31:0] status;
    logic        fault;
    logic        tmo;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] data, input logic [31:0] status,
                      input logic fault, input logic tmo, input int unsigned at);
    exp_t e;
    e.tag = tag; e.data = data; e.status = status; e.fault = fault; e.tmo = tmo; e.at = at;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_resp_valid", resp_valid, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_data"},    resp_data,    e.data);
        check({e.tag, "_status"},  resp_status,  e.status);
        check({e.tag, "_fault"},   resp_fault,   e.fault);
        check({e.tag, "_timeout"}, resp_timeout, e.tmo);
        check({e.tag, "_cycle"},   cyc,          e.at);
      end
    end
  end

  task automatic issue(input logic rw, input logic [7:0] a, input logic [31:0] wd,
                       output int unsigned acc);
    @(negedge clk);
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    check("issue_ready", cmd_ready, 32'd1);
    ack_base        = acks;
    cmd_valid       = 1'b1;
    cmd_RW          = rw;
    cmd_reg_address = a;
    cmd_data        = wd;
    acc             = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned acc, start;
    reset = 1'b1; cmd_valid = 1'b0; cmd_RW = 1'b0; cmd_reg_address = '0; cmd_data = '0;
    mode = 2'd0; d1 = '0; d2 = '0; nFault = 1'b1; ack_base = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",   cmd_ready,              32'd1);
    check("rst_resp_valid",  resp_valid,             32'd0);
    check("rst_resp_data",   resp_data,              32'd0);
    check("rst_resp_status", resp_status,            32'd0);
    check("rst_resp_fault",  resp_fault,             32'd0);
    check("rst_resp_tmo",    resp_timeout,           32'd0);
    check("rst_hs1",         handshake_1,            32'd0);
    check("rst_rav",         register_address_valid, 32'd0);
    check("rst_reg_address", reg_address,            32'd0);
    check("rst_data_out",    data_out,               32'd0);
    reset = 1'b0;

    // Write with immediate acks
    d1 = 32'hDEAD0001; d2 = 32'h000000A5;
    issue(1'b0, 8'h05, 32'h12345678, acc);
    push("wr05", 32'h0, 32'h000000A5, 1'b0, 1'b0, acc + 6);
    @(negedge clk);
    check("wr_addr_rav",   register_address_valid, 32'd1);
    check("wr_addr_hs1",   handshake_1,            32'd0);
    check("wr_reg_addr",   reg_address,            32'h05);
    check("wr_RW",         RW,                     32'd0);
    check("wr_busy_ready", cmd_ready,              32'd0);
    @(negedge clk);
    check("wr_ph1_hs1",      handshake_1, 32'd1);
    check("wr_ph1_data_out", data_out,    32'h12345678);
    repeat (2) @(negedge clk);
    check("wr_ph2_data_out", data_out,    32'h0);
    wait_sb();

    // Read with data then status
    d1 = 32'hCAFEF00D; d2 = 32'h00000001;
    issue(1'b1, 8'h03, 32'hFFFF0000, acc);
    push("rd03", 32'hCAFEF00D, 32'h00000001, 1'b0, 1'b0, acc + 6);
    @(negedge clk);
    check("rd_RW",       RW,       32'd1);
    @(negedge clk);
    check("rd_data_out", data_out, 32'h0);
    wait_sb();

    // Faulting read of an unmapped register
    d1 = 32'h55555555; d2 = 32'hAAAAAAAA; nFault = 1'b0;
    issue(1'b1, 8'hFE, 32'h0, acc);
    push("rdfault", 32'h55555555, 32'hAAAAAAAA, 1'b1, 1'b0, acc + 6);
    wait_sb();
    nFault = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_resp_data",  resp_data,  32'h55555555);
    check("hold_resp_fault", resp_fault, 32'd1);
    check("hold_resp_valid", resp_valid, 32'd0);

    // cmd_valid held through a busy transaction: one accept per DONE
    d1 = 32'h0; d2 = 32'h00000042;
    start = accepts;
    @(negedge clk);
    ack_base = acks;
    cmd_valid = 1'b1; cmd_RW = 1'b0; cmd_reg_address = 8'h10; cmd_data = 32'h11111111;
    acc = cyc;
    push("held_a", 32'h0, 32'h00000042, 1'b0, 1'b0, acc + 6);
    push("held_b", 32'h0, 32'h00000042, 1'b0, 1'b0, acc + 13);
    repeat (3) @(negedge clk);
    check("held_busy_ready", cmd_ready, 32'd0);
    repeat (7) @(negedge clk);
    cmd_valid = 1'b0;
    wait_sb();
    check("held_accepts", accepts - start, 32'd2);

    // Reset while parked in the phase-2 release wait
    d1 = 32'h01020304; d2 = 32'h00000005;
    issue(1'b1, 8'h44, 32'h0, acc);
    repeat (4) @(negedge clk);
    check("p2_ack_hs1", handshake_1, 32'd1);
    mode = 2'd2;
    @(negedge clk);
    check("p2_rel_hs1", handshake_1,            32'd0);
    check("p2_rel_rav", register_address_valid, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready",     cmd_ready,              32'd1);
    check("midrst_hs1",       handshake_1,            32'd0);
    check("midrst_rav",       register_address_valid, 32'd0);
    check("midrst_resp_data", resp_data,              32'd0);
    check("midrst_reg_addr",  reg_address,            32'd0);
    check("midrst_valid",     resp_valid,             32'd0);
    reset = 1'b0;
    mode  = 2'd0;

    // Subsystem never acknowledges
    mode = 2'd1;
    issue(1'b0, 8'h30, 32'h00000077, acc);
`ifdef BUS_TIMEOUT_EN
    push("timeout", 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, acc + 18);
    wait_sb();
`else
    repeat (40) @(negedge clk);
    check("noack_hs1_waiting", handshake_1,  32'd1);
    check("noack_rav",         register_address_valid, 32'd1);
    check("noack_timeout",     resp_timeout, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    mode = 2'd0;

    // Normal traffic resumes
    d1 = 32'h0BADBEEF; d2 = 32'h00000002;
    issue(1'b1, 8'h22, 32'h0, acc);
    push("rd22", 32'h0BADBEEF, 32'h00000002, 1'b0, 1'b0, acc + 6);
    wait_sb();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
